motoro3_cmd_cond: RTL
=====================

# motoro3_cmd_cond

Front-panel command conditioner for the 3-phase motor driver. It synchronises and debounces five raw push-button inputs and drives the `m3start`, `m3forceStop`, `m3invRotate`, `m3freqINC` and `m3freqDEC` inputs of `motoro3_top`. Frequency buttons get single-shot pulses with optional auto-repeat. Sits directly upstream of `motoro3_top` in the same 10 MHz `clk` domain.

## Interface
- DEB_CYC, 10000: consecutive stable cycles required to accept a level change (1 ms at 10 MHz); ≥2.
- RPT_DLY, 5000000: cycles from first INC/DEC pulse to first repeat pulse (0.5 s).
- RPT_PER, 1000000: cycles between subsequent repeat pulses (0.1 s); ≥2.
- clk  in  1  system clock, 10 MHz.
- rst  in  1  reset; one clock, synchronous, active-high.
- btnStart, btnStop, btnInv, btnInc, btnDec  in  1 each  raw active-high buttons, asynchronous, bouncing.
- m3start  out  1  one-cycle start pulse.
- m3forceStop  out  1  level; debounced stop button.
- m3invRotate  out  1  level; direction, toggled per press.
- m3freqINC, m3freqDEC  out  1 each  one-cycle step pulses.

## Operation
- Per button: 2-flop synchroniser → debouncer. Debounced state `deb` flips after DEB_CYC consecutive cycles of synced value ≠ `deb`. Any equal sample clears the counter.
- Press event = `deb` rising edge. Release event = `deb` falling edge.
- m3start: pulse on Start press, only if stop `deb`=0.
- m3forceStop: equals stop `deb`, registered.
- m3invRotate: toggles on each Inv press. Independent of stop.
- INC/DEC each have an FSM with states IDLE, HOLD_DLY, REPEAT and a shared-width repeat counter.
  - IDLE, on press: pulse, load counter with RPT_DLY, go to HOLD_DLY.
  - HOLD_DLY, counter expires: pulse, load counter with RPT_PER, go to REPEAT.
  - REPEAT, counter expires: pulse, reload counter with RPT_PER.
  - Release, from any state: go to IDLE with no pulse.
- Priority: INC over DEC.
  - While INC `deb`=1, DEC FSM is forced to IDLE and emits no pulses. m3freqINC and m3freqDEC are never high together.
  - On INC release with DEC `deb` still 1, DEC treats it as a new press and pulses one cycle later.
- Stop dominance: while stop `deb`=1, both FSMs are forced to IDLE and start/INC/DEC pulses are suppressed. A button still held when stop releases does not fire; a fresh press is required. Exception: DEC after INC release, as stated above.
- Reset: all outputs 0; all synchroniser/debounce states 0; counters 0; FSMs IDLE; m3invRotate 0.
- Reset mid-operation: a pending repeat is cancelled. Buttons held through reset are seen as presses after DEB_CYC+3 edges.

## Timing
- Press latency: raw input high and stable from before edge 1 → pulse output high in the cycle after edge DEB_CYC+2, i.e. registered at edge DEB_CYC+3. Release latency is the same for m3forceStop.
- Pulses are exactly one cycle wide.
- Repeat pulse n≥2 occurs RPT_DLY + (n−2)·RPT_PER cycles after the first pulse.
- Counter widths are $clog2 of the maximum parameter value. Counters never wrap; they load on entry and count down to 1.

## Configuration
- Macro M3CMD_AUTOREPEAT_EN.
  - Defined: the FSMs behave as above.
  - Undefined: HOLD_DLY and REPEAT are not built. Exactly one pulse per press; the FSM returns to IDLE only on release. RPT_DLY and RPT_PER are ignored.

## Structure
- Shared package `motoro3_pkg`:
  - default DEB_CYC, RPT_DLY and RPT_PER constants;
  - FSM state typedef (IDLE, HOLD_DLY, REPEAT).
- Sub-module `motoro3_debounce` (synchroniser plus debouncer, outputs `deb`, `rise`, `fall`), instantiated five times.

## Test plan
Use DEB_CYC=4, RPT_DLY=20, RPT_PER=8, reset for 3 cycles.
- Clean Start press held 30 cycles → m3start single pulse registered at edge 7 after the rise; no second pulse.
- Start input bouncing 1,0,1,0 over 4 cycles then stable high → exactly one m3start pulse, 7 edges after the last bounce.
- INC held 60 cycles with AUTOREPEAT_EN → pulses at P, P+20, P+28, P+36, P+44, P+52. Without the macro → only P.
- INC held, then DEC pressed, then INC released → no m3freqDEC while INC `deb`=1. m3freqDEC pulses 1 cycle after INC `deb` falls. Never both high together.
- Stop held, then Start and INC pressed → m3forceStop=1, no start/INC pulses. Release Stop while Start still held → still no m3start.
- Three Inv presses → m3invRotate goes 1,0,1. Assert rst mid-sequence → all outputs 0 on the next edge.

Source files
------------

// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 front-panel command path: default
// timing constants, the auto-repeat FSM state type and a counter-width helper.
package motoro3_pkg;

  // 10 MHz clock: 1 ms debounce, 0.5 s first repeat, 0.1 s repeat period.
  localparam int DEB_CYC_DEF = 10000;
  localparam int RPT_DLY_DEF = 5000000;
  localparam int RPT_PER_DEF = 1000000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    REPEAT   = 2'd2
  } rptState_t;

  // Bits needed to hold maxVal itself, so a counter loaded with it never wraps.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/motoro3_cmd_cond_if.sv
// Front-panel bundle: raw buttons in, conditioned motoro3_top commands out.
// The panel side uses master, the conditioner uses slave.
interface motoro3_cmd_cond_if;

  logic btnStart;
  logic btnStop;
  logic btnInv;
  logic btnInc;
  logic btnDec;

  logic m3start;
  logic m3forceStop;
  logic m3invRotate;
  logic m3freqINC;
  logic m3freqDEC;

  modport master (
    output btnStart, btnStop, btnInv, btnInc, btnDec,
    input  m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC
  );

  modport slave (
    input  btnStart, btnStop, btnInv, btnInc, btnDec,
    output m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC
  );

endinterface

// File: rtl/motoro3_debounce.sv
// One button: 2-flop synchroniser followed by a counting debouncer.
// deb changes after DEB_CYC consecutive synced samples that differ from it;
// rise/fall are one-cycle pulses aligned with the deb change.
module motoro3_debounce
  import motoro3_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic deb,
  output logic rise,
  output logic fall
);

  localparam int              CW   = cntWidth(DEB_CYC - 1);
  localparam logic [CW-1:0]   LAST = CW'(DEB_CYC - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after an unbroken run of samples.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking here would let sync[1] see this cycle's sync[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      deb  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt  <= '0;
        deb  <= sync[1];
        rise <= sync[1];
        fall <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/motoro3_cmd_cond.sv
// Front-panel command conditioner for motoro3_top. Debounces five buttons and
// turns them into start/step pulses, a stop level and a direction toggle.
// Stop dominates everything except the direction toggle; INC dominates DEC.
// Build option M3CMD_AUTOREPEAT_EN adds hold-to-repeat on the INC/DEC buttons;
// without it each press gives exactly one step pulse.
module motoro3_cmd_cond
  import motoro3_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int RPT_DLY = RPT_DLY_DEF,
  parameter int RPT_PER = RPT_PER_DEF
) (
  input logic               clk,
  input logic               rst,
  motoro3_cmd_cond_if.slave bus
);

  // Button slots in the debounce vectors.
  localparam int START = 0;
  localparam int STOP  = 1;
  localparam int INV   = 2;
  localparam int INC   = 3;
  localparam int DEC   = 4;

  // Step channels.
  localparam int CH_INC = 0;
  localparam int CH_DEC = 1;

  logic [4:0] rawBtn;
  logic [4:0] deb;
  logic [4:0] rise;
  logic [4:0] fall;

  assign rawBtn = {bus.btnDec, bus.btnInc, bus.btnInv, bus.btnStop, bus.btnStart};

  for (genvar i = 0; i < 5; i++) begin : gDeb
    motoro3_debounce #(.DEB_CYC(DEB_CYC)) uDeb (
      .clk  (clk),
      .rst  (rst),
      .btn  (rawBtn[i]),
      .deb  (deb[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Debounce outputs with no consumer here, gathered so they read as intentional.
  logic unusedDeb;
  assign unusedDeb = ^{deb[START], deb[INV], rise[STOP],
                       fall[START], fall[STOP], fall[INV], fall[DEC]};

  // Per-channel step control. Releasing INC while DEC is still held counts as
  // a fresh DEC press, so DEC takes over without needing a re-press.
  logic [1:0] press;
  logic [1:0] held;
  logic [1:0] forceIdle;
  logic [1:0] pulse;

  assign press     = {rise[DEC] | (fall[INC] & deb[DEC]), rise[INC]};
  assign held      = {deb[DEC], deb[INC]};
  assign forceIdle = {deb[STOP] | deb[INC], deb[STOP]};

`ifdef M3CMD_AUTOREPEAT_EN
  localparam int            CW       = cntWidth((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER);
  localparam logic [CW-1:0] DLY_LOAD = CW'(RPT_DLY);
  localparam logic [CW-1:0] PER_LOAD = CW'(RPT_PER);

  rptState_t     state     [2];
  rptState_t     stateNext [2];
  logic [CW-1:0] cnt       [2];
  logic [CW-1:0] cntNext   [2];

  // Repeat FSM state and countdown registers; reset cancels any pending repeat.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end else begin
        state[i] <= stateNext[i];
        cnt[i]   <= cntNext[i];
      end
    end
  end

  // Next state, counter load/decrement and step pulse per channel.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stateNext[i] = state[i];
      cntNext[i]   = cnt[i];
      pulse[i]     = 1'b0;
      if (forceIdle[i] || !held[i]) begin
        stateNext[i] = IDLE;
        cntNext[i]   = '0;
      end else begin
        case (state[i])
          IDLE: begin
            if (press[i]) begin
              pulse[i]     = 1'b1;
              cntNext[i]   = DLY_LOAD;
              stateNext[i] = HOLD_DLY;
            end
          end
          HOLD_DLY: begin
            if (cnt[i] == CW'(1)) begin
              pulse[i]     = 1'b1;
              cntNext[i]   = PER_LOAD;
              stateNext[i] = REPEAT;
            end else begin
              cntNext[i] = cnt[i] - CW'(1);
            end
          end
          REPEAT: begin
            if (cnt[i] == CW'(1)) begin
              pulse[i]   = 1'b1;
              cntNext[i] = PER_LOAD;
            end else begin
              cntNext[i] = cnt[i] - CW'(1);
            end
          end
          default: begin
            stateNext[i] = IDLE;
            cntNext[i]   = '0;
          end
        endcase
      end
    end
  end
`else
  // Press events are already single-cycle, so one pulse per press needs no
  // state: the channel simply stays idle until the next debounced press.
  assign pulse = press & held & ~forceIdle;
`endif

  // Registered command outputs toward motoro3_top.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m3start     <= 1'b0;
      bus.m3forceStop <= 1'b0;
      bus.m3invRotate <= 1'b0;
      bus.m3freqINC   <= 1'b0;
      bus.m3freqDEC   <= 1'b0;
    end else begin
      bus.m3start     <= rise[START] & ~deb[STOP];
      bus.m3forceStop <= deb[STOP];
      if (rise[INV]) begin
        bus.m3invRotate <= ~bus.m3invRotate;
      end
      bus.m3freqINC   <= pulse[CH_INC];
      bus.m3freqDEC   <= pulse[CH_DEC];
    end
  end

endmodule
